// File: rtl/pattern_pkg.sv
// pattern_pkg
//   Shared definitions for the pattern encoder/decoder pair.
//   - PAT_N / PAT_CW : default number of event lines and code width.
//   - PAT_ONEHOT     : code-to-one-hot mapping shared with the 2-to-4
//                      decoder (code 0 <-> 4'b0001 ... code 3 <-> 4'b1000).
//   - pat_next_idx   : wrap-around increment of a code index.
package pattern_pkg;

  localparam int PAT_N  = 4;
  localparam int PAT_CW = 2;

  // Entry i is the one-hot pattern that code i decodes to.
  localparam logic [PAT_N-1:0] PAT_ONEHOT [PAT_N] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000
  };

  // Index following i, wrapping from PAT_N-1 back to 0.
  function automatic logic [PAT_CW-1:0] pat_next_idx(input logic [PAT_CW-1:0] i);
    return (i == PAT_CW'(PAT_N - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_encoder_if.sv
// pattern_encoder_if
//   Code output channel of the pattern encoder.
//   Signals:
//     out       : encoded index (CW bits)
//     out_valid : out holds a code
//     out_ready : consumer accepts out this cycle
//   Handshake: a transfer happens on every rising clock edge where
//   out_valid && out_ready. Once out_valid is high, out and out_valid stay
//   stable until that transfer; the producer never retracts or changes a
//   presented code. out_ready may depend on out_valid, not the reverse.
//   Modports: master = encoder (producer), slave = consumer.
interface pattern_encoder_if #(
  parameter int CW = 2
);
  logic [CW-1:0] out;
  logic          out_valid;
  logic          out_ready;

  modport master (output out, output out_valid, input out_ready);
  modport slave  (input out, input out_valid, output out_ready);
endinterface

// File: rtl/pattern_prio_pick.sv
// pattern_prio_pick
//   Combinational request picker. Searches req starting at index 'start'
//   and wrapping around; the first set bit found wins.
//   Ports:
//     req   : request vector (N bits)
//     start : first index to examine
//     idx   : index of the winning request (0 when none)
//     found : at least one request is set
module pattern_prio_pick #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] start,
  output logic [CW-1:0] idx,
  output logic          found
);

  localparam int SW = CW + 1;

  logic [N-1:0] rot;
  logic [SW-1:0] sum;

  always_comb begin
    // Rotate so that bit 'start' lands at position 0; a plain lowest-index
    // search on the rotated vector then implements the wrapped search.
    rot   = N'({req, req} >> start);
    found = 1'b0;
    sum   = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, start} + SW'(k);
      end
    end
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx = sum[CW-1:0];
  end

endmodule

// File: rtl/pattern_encoder.sv
// pattern_encoder
//   Event-to-code encoder/serializer. Event pulses on 'in' are captured into
//   a pending vector and emitted one index code per handshake on the output
//   channel. Its output can drive the pattern decoder directly.
//   Ports:
//     clk     : rising-edge clock
//     rst     : asynchronous active-high reset
//     in      : event pulses, bit i requests code i
//     en      : capture enable (in ignored when 0)
//     busy    : events pending or a code presented
//     ovf     : sticky overflow (event arrived for an already pending bit)
//     ovf_clr : synchronous clear of ovf (a same-cycle overflow wins)
//     bus     : code output channel (out / out_valid / out_ready)
//   Configuration macro PATTERN_ENCODER_RR_EN:
//     defined   -> round-robin pick with a rotating start pointer
//     undefined -> fixed lowest-index priority, no pointer register
module pattern_encoder
  import pattern_pkg::*;
#(
  parameter int N  = PAT_N,
  parameter int CW = PAT_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in,
  input  logic              en,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr,
  pattern_encoder_if.master bus
);

  logic [N-1:0]  pend;
  logic [N-1:0]  pend_next;
  logic [N-1:0]  cap;
  logic [N-1:0]  clr_mask;
  logic [CW-1:0] start;
  logic [CW-1:0] pick;
  logic          found;
  logic          slot_free;
  logic          load;
  logic          ovf_set;

  pattern_prio_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req   (pend),
    .start (start),
    .idx   (pick),
    .found (found)
  );

`ifdef PATTERN_ENCODER_RR_EN
  logic [CW-1:0] ptr;

  // Search resumes just past the last loaded index so every line is served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (pick == CW'(N - 1)) ? '0 : pick + 1'b1;
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    slot_free = !bus.out_valid || bus.out_ready;
    load      = slot_free && found;
    clr_mask  = load ? (N'(1) << pick) : '0;
    cap       = en ? in : '0;
    // A bit loaded into the output and re-captured in the same cycle simply
    // stays pending; only a hit on a bit that remains pending is a duplicate.
    pend_next = (pend & ~clr_mask) | cap;
    ovf_set   = |(cap & pend & ~clr_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend          <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      pend <= pend_next;
      if (slot_free) begin
        bus.out_valid <= found;
        if (found) begin
          bus.out <= pick;
        end
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Derived from registers only: no path from 'in' to any output.
  assign busy = (|pend) | bus.out_valid;

endmodule

// File: tb/tb_pattern_encoder.sv
// tb_pattern_encoder
//   Directed, table-driven bench for pattern_encoder. Each table row is one
//   clock cycle of inputs plus the outputs expected just after that edge.
//   Hand-written sequences cover reset state and asynchronous reset.
module tb_pattern_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] ev_in;
  logic       en;
  logic       busy;
  logic       ovf;
  logic       ovf_clr;

  pattern_encoder_if #(.CW(2)) bus ();

  pattern_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .in      (ev_in),
    .en      (en),
    .busy    (busy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic       en;
    logic       rdy;
    logic       clr;
    logic       exp_v;
    logic [1:0] exp_out;
    logic       exp_busy;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[$];
  int   n_checks;
  int   n_errors;

  task automatic add(input logic r, input logic [3:0] i, input logic e,
                     input logic rd, input logic c, input logic v,
                     input logic [1:0] o, input logic b, input logic f);
    vec_t x;
    x.rst = r; x.in = i; x.en = e; x.rdy = rd; x.clr = c;
    x.exp_v = v; x.exp_out = o; x.exp_busy = b; x.exp_ovf = f;
    tbl.push_back(x);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, "_valid"}, 8'(bus.out_valid), 8'(v.exp_v));
    check({tag, "_out"},   8'(bus.out),       8'(v.exp_out));
    check({tag, "_busy"},  8'(busy),          8'(v.exp_busy));
    check({tag, "_ovf"},   8'(ovf),           8'(v.exp_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst           = v.rst;
    ev_in         = v.in;
    en            = v.en;
    bus.out_ready = v.rdy;
    ovf_clr       = v.clr;
    @(posedge clk);
    #1;
    check_all(tag, v);
  endtask

  logic [1:0] rr_seq [5];

  initial begin
    vec_t rv;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; ev_in = '0; en = 1'b0; bus.out_ready = 1'b0; ovf_clr = 1'b0;

`ifdef PATTERN_ENCODER_RR_EN
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    rr_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Single event: code 2 appears two edges after capture, for one cycle.
    add(0, 4'b0100, 1, 1, 0,  0, 2'd0, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  1, 2'd2, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd2, 0, 0);
    add(1, 4'b0000, 0, 1, 0,  0, 2'd0, 0, 0);
    // Multi-hot 1011 -> 0,1,3; en=0 rows ignore 'in' while draining.
    add(0, 4'b1011, 1, 1, 0,  0, 2'd0, 1, 0);
    add(0, 4'b0100, 0, 1, 0,  1, 2'd0, 1, 0);
    add(0, 4'b0100, 0, 1, 0,  1, 2'd1, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  1, 2'd3, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd3, 0, 0);
    // Backpressure: code 0 held five cycles, then 0 transfers and 1 follows.
    add(0, 4'b0011, 1, 0, 0,  0, 2'd3, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 4'b0000, 1, 0, 0,  1, 2'd0, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  1, 2'd1, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd1, 0, 0);
    // Overflow under stall: duplicate 0010 merged, one code 1, then cleared.
    add(0, 4'b0001, 1, 0, 0,  0, 2'd1, 1, 0);
    add(0, 4'b0010, 1, 0, 0,  1, 2'd0, 1, 0);
    add(0, 4'b0010, 1, 0, 0,  1, 2'd0, 1, 1);
    add(0, 4'b0000, 1, 1, 0,  1, 2'd1, 1, 1);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd1, 0, 1);
    add(0, 4'b0000, 1, 1, 1,  0, 2'd1, 0, 0);
    // Overflow and ovf_clr in the same cycle: set wins.
    add(0, 4'b0001, 1, 0, 0,  0, 2'd1, 1, 0);
    add(0, 4'b0010, 1, 0, 0,  1, 2'd0, 1, 0);
    add(0, 4'b0010, 1, 0, 1,  1, 2'd0, 1, 1);
    add(0, 4'b0000, 1, 1, 1,  1, 2'd1, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd1, 0, 0);
    // Repeat of a bit while it is loaded: stays pending, no overflow.
    add(0, 4'b0100, 1, 1, 0,  0, 2'd1, 1, 0);
    add(0, 4'b0100, 1, 1, 0,  1, 2'd2, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  1, 2'd2, 1, 0);
    add(0, 4'b0000, 1, 1, 0,  0, 2'd2, 0, 0);
    // All lines held: fixed priority repeats 0, round-robin rotates.
    add(1, 4'b0000, 0, 1, 0,  0, 2'd0, 0, 0);
    add(0, 4'b1111, 1, 1, 0,  0, 2'd0, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 4'b1111, 1, 1, 0,  1, rr_seq[k], 1, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rv.exp_v = 1'b0; rv.exp_out = 2'd0; rv.exp_busy = 1'b0; rv.exp_ovf = 1'b0;
    check_all("reset", rv);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset mid-stream: outputs drop without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 8'(bus.out_valid), 8'd0);
    check("async_out",   8'(bus.out),       8'd0);
    check("async_busy",  8'(busy),          8'd0);
    check("async_ovf",   8'(ovf),           8'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ev_in = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_valid%0d", k), 8'(bus.out_valid), 8'd0);
      check($sformatf("post_rst_busy%0d", k),  8'(busy),          8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_encoder.md
# pattern_encoder

Event-to-code encoder and serializer. It is the encode-side counterpart of the 2-to-4 pattern decoder. It captures one-hot or multi-hot event pulses on a 4-bit input, holds them as pending requests, and emits one 2-bit index code per handshake on a valid/ready output. It sits between event sources and any consumer that expects pattern codes, and its output can drive the pattern decoder directly.

## Interface
Parameters:
- N, 4, number of event lines.
- CW, 2, code width; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in  in  N  event pulses; bit i requests code i.
- en  in  1  capture enable; when 0, `in` is ignored.
- out  out  CW  encoded index.
- out_valid  out  1  `out` holds a code.
- out_ready  in  1  consumer accepts `out` this cycle.
- busy  out  1  `|pend | out_valid`.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of `ovf`.

## Operation
- `pend[N-1:0]` holds captured but not yet emitted events.
- Output slot is free when `!out_valid || out_ready`.
- Pick rule (default, fixed priority): lowest set index of `pend` wins. Bit 0 maps to code 0, matching the decoder mapping of 0 to 4'b0001.
- Output slot free and `pend != 0`:
  - `out <= pick`, `out_valid <= 1`.
  - Picked bit is cleared from `pend`.
- Output slot free and `pend == 0`: `out_valid <= 0`. `out` holds its last value.
- Output slot not free (`out_valid && !out_ready`): `out`, `out_valid` and `pend` picks are stable. No code is dropped or changed while stalled.
- Capture: `pend_next = (pend & ~clr_mask) | (en ? in : 0)`.
- Same bit captured and cleared in one cycle: the bit stays pending. No overflow in this case.
- Overflow: `en && in[i] && pend[i] && !clr_mask[i]` sets `ovf`. The duplicate event is merged, never counted twice.
- `ovf_clr` and a new overflow in the same cycle: `ovf` stays 1 (set wins).
- `en = 0`: pending events continue to drain normally.

## Timing
- Reset values: `pend = 0`, `out = 0`, `out_valid = 0`, `ovf = 0`, `busy = 0`, round-robin pointer = 0.
- Reset mid-operation discards pending and in-flight codes immediately (asynchronous).
- Latency from input to output is 2 cycles:
  - `in[i]` sampled at edge E.
  - Pending at E.
  - `out_valid` with `out = i` after edge E+1, provided the slot is free and `i` wins the pick.
- Throughput is one code per cycle while `out_ready = 1`.
- Transfer occurs on an edge where `out_valid && out_ready`.
- `busy` and `ovf` are registered or derived from registers only. There is no combinational path from `in` to any output.

## Configuration
- `PATTERN_ENCODER_RR_EN` defined:
  - Round-robin pick. Search starts at index `ptr` and wraps.
  - On each load, `ptr <= (pick + 1) mod N`; 3 wraps to 0.
  - Reset value of `ptr` is 0.
- `PATTERN_ENCODER_RR_EN` undefined:
  - Fixed lowest-index priority.
  - No pointer register exists.

## Structure
- Shared package `pattern_pkg`:
  - Holds N and CW defaults.
  - Holds the one-hot-to-index mapping constants shared with the decoder.
- One sub-module, `pattern_prio_pick`:
  - Combinational.
  - Inputs: request vector, start pointer.
  - Outputs: `CW`-bit index and `found`.
  - Start pointer is tied to 0 when `PATTERN_ENCODER_RR_EN` is undefined.

## Test plan
- Single event: reset, then `en = 1`, `in = 4'b0100` for 1 cycle, `out_ready = 1` -> `out_valid` rises 2 cycles later with `out = 2`, for exactly 1 cycle; `busy` returns to 0.
- Multi-hot, fixed priority: `in = 4'b1011` for 1 cycle -> codes 0, 1, 3 on consecutive cycles. With `PATTERN_ENCODER_RR_EN`, same order from `ptr = 0`.
- Backpressure: `in = 4'b0011`, `out_ready = 0` for 5 cycles -> `out = 0` held stable with `out_valid = 1`; after `out_ready = 1`, codes 0 then 1.
- Overflow: `in = 4'b0010` pending under stall, repeat `in = 4'b0010` -> `ovf = 1` and only one code 1 emitted. `ovf_clr` then clears it. A same-cycle repeat where the bit is being loaded into the output sets no `ovf`.
- Round-robin fairness (RR build): `in = 4'b1111` held with `en = 1` -> output sequence 0, 1, 2, 3, 0, … with no starvation.
- Async reset: assert `rst` mid-stream while `out_valid = 1` -> `out_valid`, `pend`, `ovf` and `busy` are 0 immediately, and no code is emitted after release.
